// File: rtl/matrix_stream_transposer.sv
// matrix_stream_transposer
//   Streaming N x N transposer: takes one matrix row per beat into a single
//   register buffer, then emits one column per beat. Fill and drain never
//   overlap, so a matrix costs at least 2N cycles.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_row/in_valid/in_ready     row r, element (r,j) at [(N-1-j)*W +: W]
//   out_col/out_valid/out_ready  column c, element (i,c) at [(N-1-i)*W +: W]
//   out_last            current column is N-1
//   out_idx             current column index (zero-extended)
//   busy                matrix partially loaded or draining
module matrix_stream_transposer #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_row,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N*W-1:0] out_col,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic [2:0]     out_idx,
    output logic           busy
);
    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [2:0] LAST = 3'(N - 1);

    state_t                  state_q, state_d;
    logic [2:0]              rcnt_q, rcnt_d;
    logic [2:0]              ccnt_q, ccnt_d;
    logic [N-1:0][N*W-1:0]   mat_q, mat_d;
    logic [N-1:0][W-1:0]     col_sel;
    logic                    accept, hshake;

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        ccnt_d    = ccnt_q;
        mat_d     = mat_q;
        // Outputs are gated by rst so the reset cycle itself shows an idle block.
        in_ready  = (state_q == FILL) && !rst;
        out_valid = (state_q == DRAIN) && !rst;
        accept    = in_valid && in_ready;
        hshake    = out_valid && out_ready;
        if (accept) begin
            for (int r = 0; r < N; r++)
                if (rcnt_q == 3'(r)) mat_d[r] = in_row;
            if (rcnt_q == LAST) begin
                rcnt_d  = '0;
                state_d = DRAIN;
            end else begin
                rcnt_d = rcnt_q + 3'd1;
            end
        end
        if (hshake) begin
            if (ccnt_q == LAST) begin
                ccnt_d  = '0;
                state_d = FILL;
            end else begin
                ccnt_d = ccnt_q + 3'd1;
            end
        end
    end

    // Element (i, ccnt) of each stored row i.
    always_comb begin
        col_sel = '0;
        for (int i = 0; i < N; i++)
            for (int c = 0; c < N; c++)
                if (ccnt_q == 3'(c)) col_sel[i] = mat_q[i][(N-1-c)*W +: W];
    end

    for (genvar i = 0; i < N; i++) begin : g_col
        assign out_col[(N-1-i)*W +: W] = out_valid ? col_sel[i] : '0;
    end

    assign out_last = out_valid && (ccnt_q == LAST);
    assign out_idx  = out_valid ? ccnt_q : 3'd0;
    assign busy     = !rst && ((state_q == DRAIN) || (rcnt_q != 3'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            rcnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    // Data buffer is never reset; a discarded partial matrix is simply overwritten.
    always_ff @(posedge clk) mat_q <= mat_d;
endmodule
